// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one Avalon-MM SDRAM controller slave between the LCD
// scan-out reader (display port "d", read-only) and the Julia compute engine
// (compute port "c", read/write). Display has fixed priority, a starvation
// counter guarantees compute progress, and a tag FIFO routes each returning
// read word to the port that issued it.
//
// Handshake: a command is accepted on a cycle where m_read|m_write is high and
// m_waitrequest is low. The granted port sees waitrequest = m_waitrequest, the
// other port sees waitrequest = 1. Once a command has been stalled, the grant
// is locked so the m_* fields stay stable until acceptance.
module sdram_arbiter #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 8,
    parameter int STARVE  = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    // display port
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,
    // compute port
    input  logic [ADDR_W-1:0]   c_address,
    input  logic                c_read,
    input  logic                c_write,
    input  logic [DATA_W-1:0]   c_writedata,
    input  logic [DATA_W/8-1:0] c_byteenable,
    output logic                c_waitrequest,
    output logic [DATA_W-1:0]   c_readdata,
    output logic                c_readdatavalid,
    // SDRAM controller master side
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    // sticky error
    output logic                err_rdv
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    localparam int SC_W  = $clog2(STARVE + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_D    = 2'd1,
        GNT_C    = 2'd2
    } grant_t;

    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    grant_t           r_grant;
    grant_t           w_grant;
    logic [SC_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_tag_mem [MAX_OUT];
    logic             r_err_rdv;

    logic w_c_req;
    logic w_full;
    logic w_empty;
    logic w_d_ok;
    logic w_c_ok;
    logic w_cmd;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Request qualification: reads are held off while the tag FIFO is full,
    // writes never are. c_read with c_write is treated as a write.
    always_comb begin
        w_c_req = c_read | c_write;
        w_full  = (r_fifo_cnt == CNT_FULL);
        w_empty = (r_fifo_cnt == '0);
        w_d_ok  = d_read & ~w_full;
        w_c_ok  = c_write | (c_read & ~w_full);
    end

    // Grant selection: locked grant wins, else compute on starvation or when
    // display is idle, else display; nothing is granted while in reset.
    always_comb begin
        w_grant = GNT_NONE;
        if (!reset_reset_n) begin
            w_grant = GNT_NONE;
        end else if (r_state == ST_LOCKED) begin
            w_grant = r_grant;
        end else if (w_c_ok && (!w_d_ok || (r_starve_cnt == SC_MAX))) begin
            w_grant = GNT_C;
        end else if (w_d_ok) begin
            w_grant = GNT_D;
        end
    end

    // Master-side mux and per-port waitrequest from the current grant.
    always_comb begin
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        d_waitrequest = 1'b1;
        c_waitrequest = 1'b1;
        case (w_grant)
            GNT_D: begin
                m_address     = d_address;
                m_read        = d_read;
                m_byteenable  = '1;
                d_waitrequest = m_waitrequest;
            end
            GNT_C: begin
                m_address     = c_address;
                m_read        = c_read & ~c_write;
                m_write       = c_write;
                m_writedata   = c_writedata;
                m_byteenable  = c_byteenable;
                c_waitrequest = m_waitrequest;
            end
            default: begin
                m_address = '0;
            end
        endcase
        w_cmd    = m_read | m_write;
        w_accept = w_cmd & ~m_waitrequest;
    end

    // Lock FSM next state: a stalled command locks the grant until it is
    // accepted (or the requester withdraws it).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_cmd && m_waitrequest) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (!w_cmd || !m_waitrequest) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Lock state and grant registers; in LOCKED the grant simply recirculates.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant;
        end
    end

    // Starvation counter: counts display accepts while compute waits.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_starve_cnt <= '0;
        end else if (!w_c_req) begin
            r_starve_cnt <= '0;
        end else if (w_accept && (w_grant == GNT_C)) begin
            r_starve_cnt <= '0;
        end else if (w_accept && (w_grant == GNT_D) && (r_starve_cnt != SC_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end

    // Tag FIFO control: push the issuing port on read accept, pop on data.
    always_comb begin
        w_push = w_accept & m_read;
        w_pop  = m_readdatavalid & ~w_empty;
        w_head = r_tag_mem[r_rd_ptr];
    end

    // Tag FIFO pointers, occupancy and sticky orphan-data error.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_err_rdv  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            if (m_readdatavalid && w_empty) r_err_rdv <= 1'b1;
        end
    end

    // Tag storage: entries are only read when the FIFO is non-empty.
    always_ff @(posedge clk_clk) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= (w_grant == GNT_C);
    end

    assign d_readdata      = m_readdata;
    assign c_readdata      = m_readdata;
    assign d_readdatavalid = w_pop & ~w_head;
    assign c_readdatavalid = w_pop & w_head;
    assign err_rdv         = r_err_rdv;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM slave model.
module tb_sdram_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_waitrequest;
    logic [DATA_W-1:0] d_readdata;
    logic              d_readdatavalid;
    logic [ADDR_W-1:0] c_address;
    logic              c_read;
    logic              c_write;
    logic [DATA_W-1:0] c_writedata;
    logic [3:0]        c_byteenable;
    logic              c_waitrequest;
    logic [DATA_W-1:0] c_readdata;
    logic              c_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic              err_rdv;

    sdram_arbiter #(.ADDR_W(22), .DATA_W(32), .MAX_OUT(8), .STARVE(16)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .d_address(d_address), .d_read(d_read), .d_waitrequest(d_waitrequest),
        .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
        .c_address(c_address), .c_read(c_read), .c_write(c_write),
        .c_writedata(c_writedata), .c_byteenable(c_byteenable),
        .c_waitrequest(c_waitrequest), .c_readdata(c_readdata),
        .c_readdatavalid(c_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .err_rdv(err_rdv)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 ^ {10'd0, a};
    endfunction

    // ---------------- SDRAM slave model ----------------
    bit          auto_rdv = 1'b0;
    int          rd_lat   = 3;
    int          pend_due_q[$];
    logic [31:0] pend_data_q[$];
    logic        man_rdv  = 1'b0;
    logic [31:0] man_data = '0;

    always @(negedge clk_clk) begin
        if (auto_rdv && reset_reset_n && m_read && !m_waitrequest) begin
            pend_due_q.push_back(cyc + rd_lat);
            pend_data_q.push_back(mem_data(m_address));
        end
    end

    initial begin
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        forever begin
            @(posedge clk_clk);
            #2;
            if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
                m_readdatavalid = 1'b1;
                m_readdata      = pend_data_q.pop_front();
                pend_due_q.delete(0);
            end else if (man_rdv) begin
                m_readdatavalid = 1'b1;
                m_readdata      = man_data;
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata      = '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_c_q[$];
    logic        order_q[$];
    int          d_rdv_cnt = 0;
    int          c_rdv_cnt = 0;

    always @(negedge clk_clk) begin
        if (d_readdatavalid || c_readdatavalid)
            check_eq("rdv_both", 32'(d_readdatavalid & c_readdatavalid), 32'd0);
        if (d_readdatavalid) begin
            d_rdv_cnt++;
            order_q.push_back(1'b0);
            if (exp_d_q.size() > 0) check_eq("d_rdata", d_readdata, exp_d_q.pop_front());
            else                    check_eq("d_rdv_unexpected", 32'(d_readdatavalid), 32'd0);
        end
        if (c_readdatavalid) begin
            c_rdv_cnt++;
            order_q.push_back(1'b1);
            if (exp_c_q.size() > 0) check_eq("c_rdata", c_readdata, exp_c_q.pop_front());
            else                    check_eq("c_rdv_unexpected", 32'(c_readdatavalid), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_address     = '0;
        d_read        = 1'b0;
        c_address     = '0;
        c_read        = 1'b0;
        c_write       = 1'b0;
        c_writedata   = '0;
        c_byteenable  = '0;
        m_waitrequest = 1'b0;
        man_rdv       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        auto_rdv = 1'b0;
        reset_reset_n = 1'b0;
        repeat (2) next_cycle();
        pend_due_q.delete();
        pend_data_q.delete();
        exp_d_q.delete();
        exp_c_q.delete();
        order_q.delete();
        d_rdv_cnt = 0;
        c_rdv_cnt = 0;
        reset_reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_m_read"},  32'(m_read), 32'd0);
        check_eq({tag, "_m_write"}, 32'(m_write), 32'd0);
        check_eq({tag, "_d_wait"},  32'(d_waitrequest), 32'd1);
        check_eq({tag, "_c_wait"},  32'(c_waitrequest), 32'd1);
        check_eq({tag, "_d_rdv"},   32'(d_readdatavalid), 32'd0);
        check_eq({tag, "_c_rdv"},   32'(c_readdatavalid), 32'd0);
        check_eq({tag, "_err"},     32'(err_rdv), 32'd0);
        check_eq({tag, "_cnt"},     32'(dut.r_fifo_cnt), 32'd0);
        check_eq({tag, "_starve"},  32'(dut.r_starve_cnt), 32'd0);
        check_eq({tag, "_state"},   32'(dut.r_state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_reset_n = 1'b1;
        #1 reset_reset_n = 1'b0;
        d_read  = 1'b1;
        c_write = 1'b1;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        check_reset_outputs("por");
        do_reset();

        // Display only: 8 back-to-back reads, latency 3
        auto_rdv = 1'b1;
        rd_lat   = 3;
        for (int i = 0; i < 8; i++) exp_d_q.push_back(mem_data(ADDR_W'(32'h100 + i)));
        for (int i = 0; i < 8; i++) begin
            d_read    = 1'b1;
            d_address = ADDR_W'(32'h100 + i);
            @(negedge clk_clk);
            check_eq("disp_addr", 32'(m_address), 32'h100 + i);
            check_eq("disp_acc",  32'(m_read & ~d_waitrequest), 32'd1);
            next_cycle();
        end
        d_read = 1'b0;
        repeat (8) next_cycle();
        check_eq("disp_d_cnt", d_rdv_cnt, 8);
        check_eq("disp_c_cnt", c_rdv_cnt, 0);
        check_eq("disp_left",  exp_d_q.size(), 0);
        check_eq("disp_err",   32'(err_rdv), 32'd0);

        // Contention: 16 display accepts then 1 compute write, repeating
        do_reset();
        auto_rdv     = 1'b1;
        rd_lat       = 3;
        d_read       = 1'b1;
        d_address    = 22'h200;
        c_write      = 1'b1;
        c_address    = 22'h300;
        c_writedata  = 32'hDEAD_0000;
        c_byteenable = 4'h5;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk_clk);
            if ((k % 17) != 16) exp_d_q.push_back(mem_data(22'h200));
            check_eq("cont_m_write", 32'(m_write), ((k % 17) == 16) ? 32'd1 : 32'd0);
            check_eq("cont_d_wait",  32'(d_waitrequest), ((k % 17) == 16) ? 32'd1 : 32'd0);
            check_eq("cont_c_wait",  32'(c_waitrequest), ((k % 17) == 16) ? 32'd0 : 32'd1);
            check_eq("cont_be",      32'(m_byteenable), ((k % 17) == 16) ? 32'h5 : 32'hF);
            check_eq("cont_starve",  32'(dut.r_starve_cnt), 32'(k % 17));
            next_cycle();
        end
        idle_inputs();
        repeat (6) next_cycle();
        check_eq("cont_d_cnt", d_rdv_cnt, 32);
        check_eq("cont_left",  exp_d_q.size(), 0);

        // Lock: stalled compute write holds m_* while display waits
        do_reset();
        auto_rdv      = 1'b1;
        rd_lat        = 3;
        c_write       = 1'b1;
        c_address     = 22'h040;
        c_writedata   = 32'h1234_5678;
        c_byteenable  = 4'hF;
        m_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                d_read    = 1'b1;
                d_address = 22'h050;
            end
            if (k == 4) m_waitrequest = 1'b0;
            @(negedge clk_clk);
            check_eq("lock_m_write", 32'(m_write), 32'd1);
            check_eq("lock_addr",    32'(m_address), 32'h040);
            check_eq("lock_wdata",   m_writedata, 32'h1234_5678);
            check_eq("lock_c_wait",  32'(c_waitrequest), (k == 4) ? 32'd0 : 32'd1);
            check_eq("lock_d_wait",  32'(d_waitrequest), 32'd1);
            check_eq("lock_state",   32'(dut.r_state), (k == 0) ? 32'd0 : 32'd1);
            next_cycle();
        end
        c_write = 1'b0;
        exp_d_q.push_back(mem_data(22'h050));
        @(negedge clk_clk);
        check_eq("lock_d_acc",  32'(m_read & ~d_waitrequest), 32'd1);
        check_eq("lock_d_addr", 32'(m_address), 32'h050);
        next_cycle();
        d_read = 1'b0;
        repeat (5) next_cycle();
        check_eq("lock_left", exp_d_q.size(), 0);

        // Tag steering: c, d, c reads with latency 5
        do_reset();
        auto_rdv = 1'b1;
        rd_lat   = 5;
        exp_c_q.push_back(mem_data(22'h010));
        exp_d_q.push_back(mem_data(22'h020));
        exp_c_q.push_back(mem_data(22'h030));
        c_read = 1'b1; c_address = 22'h010;
        next_cycle();
        c_read = 1'b0; d_read = 1'b1; d_address = 22'h020;
        next_cycle();
        d_read = 1'b0; c_read = 1'b1; c_address = 22'h030;
        next_cycle();
        c_read = 1'b0;
        repeat (8) next_cycle();
        check_eq("tag_n", order_q.size(), 3);
        if (order_q.size() == 3) begin
            check_eq("tag_0", 32'(order_q[0]), 32'd1);
            check_eq("tag_1", 32'(order_q[1]), 32'd0);
            check_eq("tag_2", 32'(order_q[2]), 32'd1);
        end
        check_eq("tag_c_cnt", c_rdv_cnt, 2);
        check_eq("tag_d_cnt", d_rdv_cnt, 1);

        // FIFO full: reads blocked, writes pass, one data return admits a read
        do_reset();
        auto_rdv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d_read    = 1'b1;
            d_address = ADDR_W'(32'h400 + i);
            @(negedge clk_clk);
            check_eq("full_fill", 32'(d_waitrequest), 32'd0);
            next_cycle();
        end
        d_address    = 22'h408;
        c_write      = 1'b1;
        c_address    = 22'h500;
        c_byteenable = 4'hF;
        @(negedge clk_clk);
        check_eq("full_cnt",     32'(dut.r_fifo_cnt), 32'd8);
        check_eq("full_d_wait",  32'(d_waitrequest), 32'd1);
        check_eq("full_c_wait",  32'(c_waitrequest), 32'd0);
        check_eq("full_m_write", 32'(m_write), 32'd1);
        check_eq("full_w_addr",  32'(m_address), 32'h500);
        next_cycle();
        c_write = 1'b0;
        @(negedge clk_clk);
        check_eq("full_d_wait2", 32'(d_waitrequest), 32'd1);
        check_eq("full_m_read",  32'(m_read), 32'd0);
        next_cycle();
        exp_d_q.push_back(mem_data(22'h400));
        man_rdv  = 1'b1;
        man_data = mem_data(22'h400);
        @(negedge clk_clk);
        check_eq("full_rdv",     32'(d_readdatavalid), 32'd1);
        check_eq("full_d_wait3", 32'(d_waitrequest), 32'd1);
        next_cycle();
        man_rdv = 1'b0;
        @(negedge clk_clk);
        check_eq("full_admit", 32'(m_read & ~d_waitrequest), 32'd1);
        check_eq("full_addr",  32'(m_address), 32'h408);
        next_cycle();
        d_read = 1'b0;
        next_cycle();
        check_eq("full_cnt2", 32'(dut.r_fifo_cnt), 32'd8);

        // Error and reset: orphan data, then reset with 3 reads outstanding
        do_reset();
        auto_rdv = 1'b0;
        man_rdv  = 1'b1;
        man_data = 32'h0BAD_0BAD;
        @(negedge clk_clk);
        check_eq("err_no_d", 32'(d_readdatavalid), 32'd0);
        check_eq("err_no_c", 32'(c_readdatavalid), 32'd0);
        check_eq("err_pre",  32'(err_rdv), 32'd0);
        next_cycle();
        man_rdv = 1'b0;
        @(negedge clk_clk);
        check_eq("err_set", 32'(err_rdv), 32'd1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            d_read    = 1'b1;
            d_address = ADDR_W'(32'h600 + i);
            @(negedge clk_clk);
            check_eq("rst_issue", 32'(d_waitrequest), 32'd0);
            next_cycle();
        end
        check_eq("rst_cnt_pre", 32'(dut.r_fifo_cnt), 32'd3);
        c_write = 1'b1;
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        check_reset_outputs("rst");
        next_cycle();
        idle_inputs();
        next_cycle();
        reset_reset_n = 1'b1;
        next_cycle();
        man_rdv  = 1'b1;
        man_data = mem_data(22'h600);
        @(negedge clk_clk);
        check_eq("late_no_d", 32'(d_readdatavalid), 32'd0);
        check_eq("late_no_c", 32'(c_readdatavalid), 32'd0);
        next_cycle();
        man_rdv = 1'b0;
        @(negedge clk_clk);
        check_eq("late_err", 32'(err_rdv), 32'd1);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port Avalon-MM arbiter sharing the single SDRAM controller slave (julia_sys SDRAM port) between the LCD scan-out reader (display port "d") and the Julia pixel compute engine (compute port "c").
- Display reads have fixed priority to avoid frame underrun. A starvation guard guarantees compute progress. A tag FIFO steers read data back to the port that issued each read.
- Single-word transfers only; no bursts.

Parameters:
- ADDR_W, 22, word address width (12 row + 8 col + 2 bank, 32-bit words)
- DATA_W, 32, data width
- MAX_OUT, 8, max outstanding reads (tag FIFO depth, power of 2)
- STARVE, 16, consecutive display grants tolerated while compute is waiting

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  async active-low reset
- d_address  in  ADDR_W  display read address
- d_read  in  1  display read request
- d_waitrequest  out  1  display stall
- d_readdata  out  DATA_W  display read data
- d_readdatavalid  out  1  display data valid
- c_address  in  ADDR_W  compute address
- c_read  in  1  compute read request
- c_write  in  1  compute write request
- c_writedata  in  DATA_W  compute write data
- c_byteenable  in  DATA_W/8  compute byte enables
- c_waitrequest  out  1  compute stall
- c_readdata  out  DATA_W  compute read data
- c_readdatavalid  out  1  compute data valid
- m_address  out  ADDR_W  to SDRAM controller
- m_read  out  1  to SDRAM controller
- m_write  out  1  to SDRAM controller
- m_writedata  out  DATA_W  to SDRAM controller
- m_byteenable  out  DATA_W/8  to SDRAM controller
- m_waitrequest  in  1  from SDRAM controller
- m_readdata  in  DATA_W  from SDRAM controller
- m_readdatavalid  in  1  from SDRAM controller
- err_rdv  out  1  sticky: readdatavalid received with no outstanding read

Behaviour:
- Reset values:
  - grant = NONE, lock = 0, starve_cnt = 0, tag FIFO empty, err_rdv = 0.
  - m_read = m_write = 0; d_readdatavalid = c_readdatavalid = 0.
  - d_waitrequest = c_waitrequest = 1 while reset is asserted.
- Request: d_req = d_read; c_req = c_read | c_write. Assertion of c_read and c_write together is illegal; treat it as a write.
- Arbitration (when lock = 0), combinational each cycle:
  - Compute wins if c_req and (!d_req or starve_cnt == STARVE).
  - Otherwise display wins if d_req.
  - Otherwise NONE.
- Read gating: a read (either port) is not presented when tag FIFO count == MAX_OUT. The port then sees waitrequest = 1, and the other port may win if its request is a write.
- The selected port's fields drive m_* combinationally. When display is selected, m_byteenable is all ones and m_write = 0.
- Acceptance: a command is accepted on a cycle where m_read|m_write is asserted and !m_waitrequest. The winner's waitrequest equals m_waitrequest; the loser's waitrequest is 1.
- Lock states (IDLE/LOCKED):
  - A command presented with m_waitrequest = 1 moves IDLE to LOCKED with the grant registered.
  - In LOCKED, the same port stays selected regardless of priority until acceptance, then returns to IDLE. This keeps m_* stable per Avalon.
- Starvation counter:
  - Increments on each display acceptance while c_req = 1, saturating at STARVE.
  - Clears on compute acceptance or on any cycle where c_req = 0.
- Tag FIFO:
  - Push port ID (0 = d, 1 = c) on each read acceptance. Pop on m_readdatavalid.
  - Head tag selects which *_readdatavalid pulses, in the same cycle (zero latency).
  - m_readdata is broadcast to both d_readdata and c_readdata.
  - Simultaneous push and pop leaves the count unchanged.
  - Full blocks new reads; writes continue.
- m_readdatavalid with FIFO empty: no valid pulse to either port, err_rdv set. err_rdv clears only on reset.
- Reset mid-operation clears all state. Outstanding reads are dropped, and their late readdatavalid sets err_rdv.

Test Plan:
- Display only: d_read at addresses 0x000100..0x000107 with m_waitrequest = 0 and read latency 3 -> 8 accepts in 8 cycles; 8 d_readdatavalid pulses matching data; c_readdatavalid stays 0.
- Contention: d_read and c_write held together continuously, STARVE = 16 -> pattern of 16 display accepts then 1 compute write accept, repeating; starve_cnt returns to 0 after each compute accept.
- Lock: compute write presented, m_waitrequest = 1 for 4 cycles, d_read asserted on cycle 2 -> m_address/m_writedata stay at the compute values for all 4 cycles; display accepted on the cycle after the write is accepted.
- Tag steering: interleave c_read(0x10), d_read(0x20), c_read(0x30), with readdatavalid 5 cycles later -> valid pulses order c, d, c with correct data.
- FIFO full: 8 reads accepted with no readdatavalid -> 9th d_read sees d_waitrequest = 1 while a c_write is still accepted; one readdatavalid then admits the read.
- Error and reset: m_readdatavalid with FIFO empty -> err_rdv = 1, no port valid. Reset asserted with 3 reads outstanding -> all outputs at reset values, FIFO count 0.
